vector_mem_arbiter: RTL and testbench

Shared vector memory and request arbiter sitting directly downstream of the four compute units' memory interfaces. Each unit raises `mem_request` as a single-cycle pulse with an op type, vector index and write data; this block latches the request, arbitrates round-robin among pending units, performs the load, store or compute-fetch against a 16-entry vector register file, and returns `mem_grant`, `mem_done` and `read_data` to the requesting unit.

---
 rtl/vector_mem_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_vector_mem_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/vector_mem_arbiter.sv
// vector_mem_arbiter
//   Shared 16-entry vector register file with a round-robin arbiter in front
//   of four compute-unit request lanes. Each lane pulses mem_request with an
//   op/index/data; the request is latched per lane and served one at a time
//   through IDLE -> ACCESS -> RESPOND (three clocks per request).
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   mem_request  per-unit single-cycle request pulse
//   mem_op_type  per-unit one-hot op: 0001 load, 0010 store, 0100 compute-fetch
//   vec_index    per-unit target entry
//   write_data   per-unit store data
//   mem_grant    per-unit one-cycle pulse, request accepted for service
//   mem_done     per-unit one-cycle pulse, service complete
//   read_data    per-unit response data, held until that unit's next mem_done
//   busy         any request pending or in service
//   err_count    saturating count of invalid ops and overwritten requests

package accel_pkg;
  localparam int VEC_LANES = 4;
  localparam int LANE_W    = 16;
  typedef logic [VEC_LANES-1:0][LANE_W-1:0] vector_data_t;
endpackage

module vector_mem_arbiter
  import accel_pkg::*;
#(
  parameter int NUM_UNITS = 4,
  parameter int MEM_DEPTH = 16,
  parameter int ERR_W     = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_UNITS-1:0]          mem_request,
  input  logic [NUM_UNITS-1:0][3:0]     mem_op_type,
  input  logic [NUM_UNITS-1:0][3:0]     vec_index,
  input  vector_data_t [NUM_UNITS-1:0]  write_data,
  output logic [NUM_UNITS-1:0]          mem_grant,
  output logic [NUM_UNITS-1:0]          mem_done,
  output vector_data_t [NUM_UNITS-1:0]  read_data,
  output logic                          busy,
  output logic [ERR_W-1:0]              err_count
);

  localparam int UID_W   = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam int ERR_MAX = (1 << ERR_W) - 1;

  localparam logic [3:0] OP_LOAD  = 4'b0001;
  localparam logic [3:0] OP_STORE = 4'b0010;
  localparam logic [3:0] OP_FETCH = 4'b0100;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESPOND} state_t;

  state_t                 state_q, state_d;
  logic [NUM_UNITS-1:0]   pend_q, pend_d;
  logic [UID_W-1:0]       rr_ptr_q;
  logic [UID_W-1:0]       sel_q;

  // Per-unit request slots, overwritten by every new request pulse
  logic [3:0]             slot_op_q   [NUM_UNITS];
  logic [3:0]             slot_idx_q  [NUM_UNITS];
  vector_data_t           slot_data_q [NUM_UNITS];

  // Copy of the granted slot; a re-request at the grant edge may overwrite
  // the slot, so service works from this snapshot.
  logic [3:0]             cur_op_q;
  logic [3:0]             cur_idx_q;
  vector_data_t           cur_data_q;
  vector_data_t           resp_q;

  vector_data_t           mem_q [MEM_DEPTH];

  logic [UID_W-1:0]       pick;
  logic [UID_W-1:0]       cand;
  logic                   found;
  logic                   grant_now;
  logic                   op_bad;
  int                     ovr_cnt;
  int                     err_sum;
  logic [ERR_W-1:0]       err_d;

  // Round-robin pick, pending bookkeeping and error accumulation
  always_comb begin
    pick  = '0;
    cand  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      cand = UID_W'((int'(rr_ptr_q) + i) % NUM_UNITS);
      if (!found && pend_q[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end

    grant_now = (state_q == S_IDLE) && (|pend_q);

    // New capture wins over the clear issued by a grant in the same cycle
    pend_d = pend_q;
    if (grant_now) pend_d[pick] = 1'b0;
    pend_d = pend_d | mem_request;

    ovr_cnt = 0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (mem_request[u] && pend_q[u] && !(grant_now && (pick == UID_W'(u))))
        ovr_cnt = ovr_cnt + 1;
    end

    op_bad = (state_q == S_ACCESS) &&
             !((cur_op_q == OP_LOAD) || (cur_op_q == OP_STORE) || (cur_op_q == OP_FETCH));

    err_sum = int'(err_count) + ovr_cnt + (op_bad ? 1 : 0);
    err_d   = (err_sum > ERR_MAX) ? ERR_W'(ERR_MAX) : ERR_W'(err_sum);

    state_d = state_q;
    case (state_q)
      S_IDLE:    if (grant_now) state_d = S_ACCESS;
      S_ACCESS:  state_d = S_RESPOND;
      S_RESPOND: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pend_q     <= '0;
      rr_ptr_q   <= '0;
      sel_q      <= '0;
      cur_op_q   <= '0;
      cur_idx_q  <= '0;
      cur_data_q <= '0;
      resp_q     <= '0;
      mem_grant  <= '0;
      mem_done   <= '0;
      read_data  <= '0;
      busy       <= 1'b0;
      err_count  <= '0;
      for (int u = 0; u < NUM_UNITS; u++) begin
        slot_op_q[u]   <= '0;
        slot_idx_q[u]  <= '0;
        slot_data_q[u] <= '0;
      end
      for (int m = 0; m < MEM_DEPTH; m++) mem_q[m] <= '0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      err_count <= err_d;
      busy      <= (|pend_d) || (state_d != S_IDLE);
      mem_grant <= '0;
      mem_done  <= '0;

      for (int u = 0; u < NUM_UNITS; u++) begin
        if (mem_request[u]) begin
          slot_op_q[u]   <= mem_op_type[u];
          slot_idx_q[u]  <= vec_index[u];
          slot_data_q[u] <= write_data[u];
        end
      end

      case (state_q)
        S_IDLE: begin
          if (grant_now) begin
            mem_grant[pick] <= 1'b1;
            sel_q           <= pick;
            cur_op_q        <= slot_op_q[pick];
            cur_idx_q       <= slot_idx_q[pick];
            cur_data_q      <= slot_data_q[pick];
          end
        end
        S_ACCESS: begin
          case (cur_op_q)
            OP_LOAD, OP_FETCH: resp_q <= mem_q[cur_idx_q];
            OP_STORE: begin
              mem_q[cur_idx_q] <= cur_data_q;
              resp_q           <= cur_data_q;
            end
            default: resp_q <= '0;
          endcase
        end
        S_RESPOND: begin
          mem_done[sel_q]  <= 1'b1;
          read_data[sel_q] <= resp_q;
          rr_ptr_q         <= (int'(sel_q) == NUM_UNITS - 1) ? '0 : sel_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_mem_arbiter.sv
module tb_vector_mem_arbiter;
  import accel_pkg::*;

  localparam logic [3:0] LD = 4'b0001;
  localparam logic [3:0] ST = 4'b0010;
  localparam logic [3:0] CF = 4'b0100;

  localparam logic [63:0] V = 64'h1234_1234_1234_1234;
  localparam logic [63:0] A = 64'hA5A5_0001_A5A5_0002;
  localparam logic [63:0] W = 64'hDEAD_BEEF_0000_0007;
  localparam logic [63:0] X = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] Z = 64'h0BAD_0BAD_0BAD_0BAD;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [3:0]             mem_request = '0;
  logic [3:0][3:0]        mem_op_type = '0;
  logic [3:0][3:0]        vec_index = '0;
  vector_data_t [3:0]     write_data = '0;
  logic [3:0]             mem_grant;
  logic [3:0]             mem_done;
  vector_data_t [3:0]     read_data;
  logic                   busy;
  logic [7:0]             err_count;

  vector_mem_arbiter #(.NUM_UNITS(4), .MEM_DEPTH(16), .ERR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .mem_request(mem_request), .mem_op_type(mem_op_type),
    .vec_index(vec_index), .write_data(write_data), .mem_grant(mem_grant),
    .mem_done(mem_done), .read_data(read_data), .busy(busy), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          unit;
    logic [63:0] data;
  } exp_t;

  int   exp_grant[$];
  exp_t exp_done[$];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every grant/done pulse is matched against the queues
  always @(negedge clk) begin
    if (mem_grant != '0) begin
      if (exp_grant.size() == 0) chk("unexpected_grant", 64'(mem_grant), 64'd0);
      else begin
        int g;
        g = exp_grant.pop_front();
        chk("grant_unit", 64'(mem_grant), 64'(1) << g);
      end
    end
    if (mem_done != '0) begin
      if (exp_done.size() == 0) chk("unexpected_done", 64'(mem_done), 64'd0);
      else begin
        exp_t e;
        e = exp_done.pop_front();
        chk("done_unit", 64'(mem_done), 64'(1) << e.unit);
        chk("done_data", read_data[e.unit], e.data);
      end
    end
  end

  // Stage one unit's request fields and push its expected grant/response
  task automatic req1(input int u, input logic [3:0] op, input logic [3:0] idx,
                      input logic [63:0] wd, input logic [63:0] rsp);
    exp_t e;
    mem_request[u] = 1'b1;
    mem_op_type[u] = op;
    vec_index[u]   = idx;
    write_data[u]  = wd;
    exp_grant.push_back(u);
    e.unit = u;
    e.data = rsp;
    exp_done.push_back(e);
  endtask

  task automatic pulse();
    @(posedge clk);
    #1;
    mem_request = '0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("idle_timeout", 64'd1, 64'd0);
    @(negedge clk);
  endtask

  task automatic single(input int u, input logic [3:0] op, input logic [3:0] idx,
                        input logic [63:0] wd, input logic [63:0] rsp);
    req1(u, op, idx, wd, rsp);
    pulse();
    wait_idle();
  endtask

  initial begin
    // Reset held for two clocks
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_grant", 64'(mem_grant), 64'd0);
    chk("rst_done", 64'(mem_done), 64'd0);
    chk("rst_read_data", 64'(read_data != '0), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(err_count), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    single(0, LD, 4'd5, 64'd0, 64'd0);

    // Store V then load it from another unit, with cycle-exact timing
    single(0, ST, 4'd3, V, V);
    req1(2, LD, 4'd3, 64'd0, V);
    pulse();
    @(negedge clk);
    chk("ld_busy_e0", 64'(busy), 64'd1);
    chk("ld_grant_e0", 64'(mem_grant), 64'd0);
    @(negedge clk);
    chk("ld_grant_e1", 64'(mem_grant), 64'h4);
    @(negedge clk);
    chk("ld_grant_e2", 64'(mem_grant), 64'd0);
    chk("ld_done_e2", 64'(mem_done), 64'd0);
    @(negedge clk);
    chk("ld_done_e3", 64'(mem_done), 64'h4);
    chk("ld_rd2_e3", read_data[2], V);
    wait_idle();
    chk("rd0_held", read_data[0], V);

    // Bring rr_ptr to 0, then four simultaneous requests
    single(3, LD, 4'd0, 64'd0, 64'd0);
    req1(0, LD, 4'd3, 64'd0, V);
    req1(1, ST, 4'd8, A, A);
    req1(2, CF, 4'd8, 64'd0, A);
    req1(3, LD, 4'd1, 64'd0, 64'd0);
    pulse();
    @(negedge clk);
    for (int e = 1; e <= 12; e++) begin
      logic [3:0] eg, ed;
      @(negedge clk);
      eg = '0;
      ed = '0;
      if (e % 3 == 1) eg[(e - 1) / 3] = 1'b1;
      if (e % 3 == 0) ed[e / 3 - 1] = 1'b1;
      chk("rr4_grant", 64'(mem_grant), 64'(eg));
      chk("rr4_done", 64'(mem_done), 64'(ed));
    end
    wait_idle();

    // Second round right after unit 3: order restarts at 0
    req1(0, CF, 4'd3, 64'd0, V);
    req1(1, LD, 4'd8, 64'd0, A);
    req1(2, ST, 4'd1, V, V);
    req1(3, LD, 4'd1, 64'd0, V);
    pulse();
    wait_idle();

    // rr_ptr = 2 after serving unit 1; units 0 and 3 -> 3 first, then 0
    single(1, LD, 4'd3, 64'd0, V);
    begin
      exp_t e;
      mem_request[0] = 1'b1; mem_op_type[0] = LD; vec_index[0] = 4'd8;
      mem_request[3] = 1'b1; mem_op_type[3] = LD; vec_index[3] = 4'd3;
      exp_grant.push_back(3);
      exp_grant.push_back(0);
      e.unit = 3; e.data = V; exp_done.push_back(e);
      e.unit = 0; e.data = A; exp_done.push_back(e);
    end
    pulse();
    wait_idle();

    // Ordering: store by unit 1 precedes load by unit 2 on the same edge
    single(3, LD, 4'd0, 64'd0, 64'd0);
    req1(1, ST, 4'd7, W, W);
    req1(2, LD, 4'd7, 64'd0, W);
    pulse();
    wait_idle();

    // Invalid op: response zero, error counted, memory untouched
    single(1, 4'b1000, 4'd7, X, 64'd0);
    chk("inv_err1", 64'(err_count), 64'd1);
    chk("inv_rd1", read_data[1], 64'd0);
    single(2, LD, 4'd7, 64'd0, W);

    for (int k = 0; k < 300; k++)
      single(0, (k % 2 == 0) ? 4'b0000 : 4'b0011, 4'd7, X, 64'd0);
    chk("err_sat", 64'(err_count), 64'd255);
    single(0, LD, 4'd7, 64'd0, W);

    // Reset while the store is in ACCESS: no done, entry stays zero
    req1(0, ST, 4'd9, Z, Z);
    void'(exp_done.pop_back());
    pulse();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_err", 64'(err_count), 64'd0);
    chk("mid_rst_rd0", read_data[0], 64'd0);
    single(0, LD, 4'd9, 64'd0, 64'd0);
    single(1, LD, 4'd3, 64'd0, 64'd0);

    chk("grant_queue_empty", 64'(exp_grant.size()), 64'd0);
    chk("done_queue_empty", 64'(exp_done.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
